// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch and ALU start/done handshakes between the sequencer and its neighbours.
// The master modport is the sequencer side.
interface instr_sequencer_if #(
    parameter int INSTR_W = 60,
    parameter int PC_W    = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               alu_start;
    logic               alu_done;

    modport master (
        output imem_req, imem_addr, alu_start,
        input  imem_ack, imem_rdata, alu_done
    );

    modport slave (
        input  imem_req, imem_addr, alu_start,
        output imem_ack, imem_rdata, alu_done
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with one instruction in flight.
// Optional macro INSTR_SEQ_RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | imem_req held with imem_addr=pc until imem_ack
// DECODE | control-unit flags latched from opcode
// EXEC   | jump/branch resolves pc, or alu_start pulse then wait for alu_done
// WB     | reg_we strobe, pc+1
module instr_sequencer #(
    parameter int INSTR_W = 60,
    parameter int PC_W    = 16,
    parameter int IMM_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    instr_sequencer_if.master  bus,
    output logic [3:0]         opcode,
    input  logic               branch_en,
    input  logic               jump_en,
    input  logic               immediate_en,
    input  logic               branch_taken,
    output logic [INSTR_W-1:0] ir,
    output logic               imm_sel,
    output logic               reg_we,
    output logic [PC_W-1:0]    pc,
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    output logic [31:0]        retire_cnt,
`endif
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB} state_t;

    state_t          state;
    logic            jmp_flag;
    logic            br_flag;
    logic [PC_W-1:0] imm_zext;
    logic [PC_W-1:0] imm_sext;
    logic [PC_W-1:0] pc_next;
    logic            at_boundary;

    assign opcode        = ir[INSTR_W-1 -: 4];
    assign bus.imem_addr = pc;

    // Jump outranks branch when the control unit raises both.
    always_comb begin
        imm_zext    = PC_W'(ir[IMM_W-1:0]);
        imm_sext    = PC_W'($signed(ir[IMM_W-1:0]));
        at_boundary = (state == WB) || ((state == EXEC) && (jmp_flag || br_flag));
        pc_next     = pc + PC_W'(1);
        if ((state == EXEC) && jmp_flag)
            pc_next = imm_zext;
        else if ((state == EXEC) && br_flag && branch_taken)
            pc_next = pc + imm_sext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= '0;
            ir            <= '0;
            jmp_flag      <= 1'b0;
            br_flag       <= 1'b0;
            imm_sel       <= 1'b0;
            reg_we        <= 1'b0;
            busy          <= 1'b0;
            bus.imem_req  <= 1'b0;
            bus.alu_start <= 1'b0;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
            retire_cnt    <= '0;
`endif
        end else begin
            bus.alu_start <= 1'b0;
            reg_we        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= FETCH;
                        bus.imem_req <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        ir           <= bus.imem_rdata;
                        bus.imem_req <= 1'b0;
                        state        <= DECODE;
                    end
                end
                DECODE: begin
                    jmp_flag      <= jump_en;
                    br_flag       <= branch_en;
                    imm_sel       <= immediate_en;
                    bus.alu_start <= !(jump_en || branch_en);
                    state         <= EXEC;
                end
                EXEC: begin
                    // alu_done is accepted in the alu_start cycle as well
                    if (!jmp_flag && !br_flag && bus.alu_done) begin
                        state  <= WB;
                        reg_we <= 1'b1;
                    end
                end
                WB: ;
                default: state <= IDLE;
            endcase

            if (at_boundary) begin
                pc <= pc_next;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
                retire_cnt <= retire_cnt + 32'd1;
`endif
                if (halt_req) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    state        <= FETCH;
                    bus.imem_req <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: an instruction-level model predicts retirement pc and strobe
// counts, a per-cycle monitor compares the DUT against it, and literal checks pin key addresses.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        branch_en, jump_en, immediate_en;
    logic        branch_taken = 1'b0;
    logic [3:0]  opcode;
    logic [59:0] ir;
    logic        imm_sel, reg_we, busy;
    logic [15:0] pc;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    instr_sequencer_if bus ();

    instr_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .halt_req     (halt_req),
        .bus          (bus),
        .opcode       (opcode),
        .branch_en    (branch_en),
        .jump_en      (jump_en),
        .immediate_en (immediate_en),
        .branch_taken (branch_taken),
        .ir           (ir),
        .imm_sel      (imm_sel),
        .reg_we       (reg_we),
        .pc           (pc),
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        .retire_cnt   (retire_cnt),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int alu_delay = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Control unit: 0000 branch, 0001 jump, 0010 immediate ALU, anything else plain ALU.
    always_comb begin
        branch_en    = (opcode == 4'h0);
        jump_en      = (opcode == 4'h1);
        immediate_en = (opcode == 4'h2);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [59:0] mk(input logic [3:0] op, input logic [15:0] imm);
        return {op, 40'hA5_C3F0_0F1E, imm};
    endfunction

    // ALU: alu_done pulses alu_delay cycles after the alu_start cycle (0 = same cycle).
    initial begin
        bus.alu_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.alu_start) begin
                repeat (alu_delay) @(negedge clk);
                bus.alu_done = 1'b1;
                @(negedge clk);
                bus.alu_done = 1'b0;
            end
        end
    end

    // Instruction-level model and per-cycle monitor.
    bit          rst_seen = 1'b0;
    logic [15:0] m_pc, m_next;
    logic [59:0] m_ir;
    bit          in_instr, m_imm, prev_req, prev_busy;
    int          m_alu, m_we, exp_alu, exp_we, m_ret;

    initial forever begin
        @(negedge rst_n);
        rst_seen = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (!rst_n || rst_seen) begin
            rst_seen  = 1'b0;
            m_pc      = '0;
            m_next    = '0;
            m_ir      = '0;
            in_instr  = 1'b0;
            m_imm     = 1'b0;
            prev_req  = 1'b0;
            prev_busy = 1'b0;
            m_alu = 0; m_we = 0; exp_alu = 0; exp_we = 0; m_ret = 0;
        end else begin
            if (bus.alu_start) m_alu++;
            if (reg_we) m_we++;
            if (in_instr && ((bus.imem_req && !prev_req) || (!busy && prev_busy))) begin
                chk("retire_pc", pc, m_next);
                chk("alu_start_cnt", m_alu, exp_alu);
                chk("reg_we_cnt", m_we, exp_we);
                m_ret++;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
                chk("retire_cnt", retire_cnt, m_ret);
`endif
                m_pc     = m_next;
                in_instr = 1'b0;
            end
            if (bus.imem_req) chk("imem_addr", bus.imem_addr, m_pc);
            chk("ir", ir, m_ir);
            chk("opcode", opcode, m_ir[59:56]);
            if (bus.alu_start || reg_we) chk("imm_sel", imm_sel, m_imm);
            if (bus.imem_req || bus.alu_start || reg_we) chk("busy", busy, 1);
            if (bus.imem_req && bus.imem_ack) begin
                logic [3:0]  op;
                logic [15:0] imm;
                int          off;
                m_ir     = bus.imem_rdata;
                op       = m_ir[59:56];
                imm      = m_ir[15:0];
                in_instr = 1'b1;
                m_alu    = 0;
                m_we     = 0;
                m_imm    = (op == 4'h2);
                if (op == 4'h1) begin
                    m_next = imm;
                    exp_alu = 0; exp_we = 0;
                end else if (op == 4'h0) begin
                    off = imm;
                    if (imm >= 16'h8000) off = off - 65536;
                    if (!branch_taken) off = 1;
                    m_next = 16'((int'(m_pc) + off) & 32'hFFFF);
                    exp_alu = 0; exp_we = 0;
                end else begin
                    m_next = m_pc + 16'd1;
                    exp_alu = 1; exp_we = 1;
                end
            end
            prev_req  = bus.imem_req;
            prev_busy = busy;
        end
    end

    task automatic wait_req(input string name);
        int n = 0;
        while (!bus.imem_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.imem_req) timeout(name);
    endtask

    task automatic wait_alu_start(input string name);
        int n = 0;
        while (!bus.alu_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.alu_start) timeout(name);
    endtask

    // Returns at the negedge of the DECODE cycle.
    task automatic serve(input logic [59:0] instr, input int dly);
        wait_req("fetch_req");
        repeat (dly) @(negedge clk);
        bus.imem_rdata = instr;
        bus.imem_ack   = 1'b1;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_alu_start", bus.alu_start, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_imm_sel", imm_sel, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while a fetch is outstanding
        pulse_start();
        serve(mk(4'h1, 16'h0033), 0);
        wait_req("fetch_33");
        chk("pc_before_rst", pc, 16'h0033);
        repeat (2) @(negedge clk);
        chk("req_before_rst", bus.imem_req, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_req", bus.imem_req, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_pc", pc, 0);
        chk("async_rst_ir", ir, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU op at pc=5, ack 3 cycles late, alu_done 2 cycles after alu_start
        alu_delay = 2;
        pulse_start();
        serve(mk(4'h1, 16'h0005), 0);
        serve(mk(4'h3, 16'h1234), 3);
        wait_alu_start("alu_start_5");
        t0 = cyc;
        n = 0;
        while (!reg_we && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!reg_we) timeout("reg_we_5");
        chk("alu_start_to_reg_we", cyc - t0, 3);
        wait_req("fetch_6");
        chk("next_addr_alu", bus.imem_addr, 16'h0006);

        // Jump
        serve(mk(4'h1, 16'h0010), 0);
        serve(mk(4'h1, 16'h0040), 0);
        wait_req("fetch_40");
        chk("next_addr_jump", bus.imem_addr, 16'h0040);

        // Branch taken / not taken with negative offset
        serve(mk(4'h1, 16'h0020), 0);
        branch_taken = 1'b1;
        serve(mk(4'h0, 16'hFFFC), 0);
        wait_req("fetch_1c");
        chk("next_addr_br_taken", bus.imem_addr, 16'h001C);
        serve(mk(4'h1, 16'h0020), 0);
        branch_taken = 1'b0;
        serve(mk(4'h0, 16'hFFFC), 1);
        wait_req("fetch_21");
        chk("next_addr_br_not", bus.imem_addr, 16'h0021);

        // ALU with alu_done in the alu_start cycle
        alu_delay = 0;
        serve(mk(4'h5, 16'h0007), 0);

        // start pulsed during EXEC is ignored
        alu_delay = 1;
        serve(mk(4'h4, 16'h0000), 0);
        wait_alu_start("alu_start_22");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_req("fetch_23");
        chk("next_addr_start_exec", bus.imem_addr, 16'h0023);
        chk("busy_after_start_exec", busy, 1);

        // Immediate op at 0xFFFF, halt during DECODE: pc wraps, sequencer idles
        serve(mk(4'h1, 16'hFFFF), 0);
        serve(mk(4'h2, 16'h00AA), 2);
        halt_req = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeout("halt_idle");
        chk("halt_pc_wrap", pc, 16'h0000);
        chk("halt_imem_req", bus.imem_req, 0);
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        chk("halt_retire_cnt", retire_cnt, 32'd12);
`endif
        halt_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_imem_req", bus.imem_req, 0);
        chk("idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute/writeback sequencer for the 60-bit processor.
- Drives the instruction-memory handshake and holds the PC and instruction register.
- Presents the opcode to the control unit and samples its branch_en/jump_en/immediate_en outputs.
- Sequences the ALU start/done handshake and register-file write strobe; one instruction in flight at a time.

Parameters:
- INSTR_W, 60, instruction width; opcode is ir[INSTR_W-1:INSTR_W-4].
- PC_W, 16, program counter width; PC wraps modulo 2^PC_W.
- IMM_W, 16, immediate/offset field width; field is ir[IMM_W-1:0]; IMM_W <= PC_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  leave IDLE and begin fetching at current pc.
- halt_req  input  1  stop at the next instruction boundary.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  PC_W  fetch address; equals pc.
- imem_ack  input  1  fetch data valid this cycle.
- imem_rdata  input  INSTR_W  fetched instruction.
- opcode  output  4  ir[INSTR_W-1:INSTR_W-4], combinational from ir.
- branch_en  input  1  from control unit.
- jump_en  input  1  from control unit.
- immediate_en  input  1  from control unit.
- branch_taken  input  1  ALU condition flag.
- ir  output  INSTR_W  instruction register.
- imm_sel  output  1  registered immediate_en; valid EXEC through WB.
- alu_start  output  1  one-cycle pulse.
- alu_done  input  1  ALU result ready.
- reg_we  output  1  register-file write strobe.
- pc  output  PC_W  program counter.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - pc=0, ir=0, imem_req=0, alu_start=0, reg_we=0, imm_sel=0, busy=0.
  - Any in-flight fetch or ALU op is abandoned.
- States: IDLE, FETCH, DECODE, EXEC, WB.
- IDLE:
  - start=1 -> FETCH next cycle.
  - halt_req is ignored in IDLE.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable until imem_ack.
  - On imem_ack: ir<=imem_rdata; imem_req low the following cycle; -> DECODE.
  - Unbounded wait is legal; no timeout.
- DECODE (exactly 1 cycle):
  - opcode is valid throughout.
  - At the cycle end, latch branch_en, jump_en and immediate_en into internal flags; imm_sel<=immediate_en.
- EXEC, jump flag set (jump has priority if both branch and jump flags are set):
  - pc<=ir[IMM_W-1:0], zero-extended.
  - -> FETCH; no WB, no alu_start.
- EXEC, branch flag set:
  - branch_taken is sampled in the first EXEC cycle.
  - Taken: pc<=pc+sign_extend(ir[IMM_W-1:0]), truncated to PC_W.
  - Not taken: pc<=pc+1.
  - -> FETCH; no WB.
- EXEC, otherwise:
  - alu_start=1 for the first EXEC cycle only.
  - Wait for alu_done, which may arrive as early as the alu_start cycle.
  - -> WB.
- WB (exactly 1 cycle):
  - reg_we=1, pc<=pc+1 (0xFFFF wraps to 0 at default PC_W).
  - -> FETCH.
- Instruction boundary = any transition out of EXEC or WB toward FETCH.
  - If halt_req=1 on that cycle, go to IDLE instead; pc is still updated.
  - halt_req during FETCH/DECODE does not abort the current instruction.
- start while busy=1 is ignored.
- Latency:
  - ALU op: 1 (FETCH with same-cycle ack) + 1 DECODE + N EXEC + 1 WB.
  - Jump/branch: FETCH + DECODE + 1 EXEC.

Optional Feature:
- Macro: INSTR_SEQ_RETIRE_CNT_EN.
- Defined: adds output retire_cnt[31:0].
  - Reset to 0; increments by 1 on every instruction boundary (jump, branch, or WB completion), including the halting one.
  - Wraps 0xFFFFFFFF->0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset mid-FETCH with imem_req=1 -> imem_req, busy, pc all 0 immediately, before the next clk edge; state IDLE.
- start, ALU opcode 0011 at pc=5, imem_ack 3 cycles late, alu_done 2 cycles after alu_start -> imem_addr stable at 5 while waiting; single alu_start pulse; reg_we one cycle; pc=6; next imem_req at addr 6.
- Jump opcode 0001 with imm=0x0040 at pc=0x0010 -> no alu_start, no reg_we; next fetch addr 0x0040.
- Branch opcode 0000 at pc=0x0020 with imm=0xFFFC:
  - branch_taken=1 -> next fetch 0x001C.
  - Repeated with branch_taken=0 -> next fetch 0x0021.
- Immediate opcode 0010 at pc=0xFFFF with halt_req=1 asserted during DECODE -> imm_sel=1 in EXEC/WB; WB completes; pc=0x0000; state IDLE; busy=0; retire_cnt +1 when macro defined.
- start pulsed during EXEC -> no effect; sequence continues normally.
